// File: rtl/accum_sequencer.sv
// accum_sequencer: frames a ready/valid product stream into accumulator vectors (start/stop,
// zero padding, bubble fill) and buffers results in a credit-checked first-word-fall-through FIFO.
package accum_pkg;
  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } complex_t;
endpackage

// Behavioural accumulator core: ADD_LAT-deep adder latency, output_valid OUT_LAT cycles after
// stop, data valid the cycle after output_valid. Overlapping vectors are resolved by start.
module accumulator
  import accum_pkg::*;
#(
  parameter int ADD_LAT = 11,
  parameter int OUT_LAT = 51
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     start,
  input  logic     stop,
  input  complex_t acc_in,
  output logic     output_valid,
  output complex_t acc_out
);
  complex_t               sum_q, sum_d;
  complex_t               hist_q [ADD_LAT];
  complex_t               res_q  [OUT_LAT+1];
  logic                   first_q;
  logic [OUT_LAT-1:0]     vld_q, vld_d;

  always_comb begin
    sum_d = acc_in;
    if (!first_q) begin
      sum_d.re = sum_q.re + acc_in.re;
      sum_d.im = sum_q.im + acc_in.im;
    end
    vld_d = {vld_q[OUT_LAT-2:0], stop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      first_q <= 1'b0;
      vld_q   <= '0;
    end else begin
      first_q <= start;
      vld_q   <= vld_d;
    end
  end

  // hist_q[ADD_LAT-1] holds the running sum as of the word ADD_LAT cycles ago
  always_ff @(posedge clk) begin
    sum_q     <= sum_d;
    hist_q[0] <= sum_d;
    for (int i = 1; i < ADD_LAT; i++) hist_q[i] <= hist_q[i-1];
    res_q[0] <= hist_q[ADD_LAT-1];
    for (int i = 1; i <= OUT_LAT; i++) res_q[i] <= res_q[i-1];
  end

  assign output_valid = vld_q[OUT_LAT-1];
  assign acc_out      = res_q[OUT_LAT];
endmodule

module accum_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic [CW-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop  = pop && (count_q != '0);
    do_push = push && ((count_q != CW'(DEPTH)) || do_pop);
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (do_pop)  rd_d = (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
    if (do_push) wr_d = (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      assert (!push || do_push);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_dat;
  end

  assign head_dat = mem_q[rd_q];
  assign count    = count_q;
endmodule

module accum_sequencer
  import accum_pkg::*;
#(
  parameter int RES_DEPTH   = 8,
  parameter int STOP_OFFSET = 11,
  parameter int CNT_W       = 16
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     in_valid,
  output logic     in_ready,
  input  complex_t in_data,
  input  logic     in_last,
  output logic     out_valid,
  input  logic     out_ready,
  output complex_t out_data,
  output logic     busy
);
  localparam int CW = $clog2(RES_DEPTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(10);

  typedef enum logic [1:0] {IDLE, RUN, PAD} state_t;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CW-1:0]          inflight_q, inflight_d, fifo_count;
  logic [CW:0]            used;
  logic                   has_credit, accept, idle_accept, push;
  logic                   w_vld, w_first, w_last;
  complex_t               w_dat, acc_in_q, acc_in_d, s1_dat_q, core_out, head;
  logic                   s1_vld_q, s1_first_q, s1_last_q, s2_last_q, ov_q;
  logic [STOP_OFFSET-1:0] stop_sr_q, stop_sr_d;
  logic                   acc_start, stop, core_ov;
  logic [$bits(complex_t)-1:0] head_raw;

  assign used        = {1'b0, fifo_count} + {1'b0, inflight_q};
  assign has_credit  = used < (CW+1)'(RES_DEPTH);
  assign accept      = in_valid && in_ready;
  assign idle_accept = accept && (state_q == IDLE);
  assign push        = ov_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        cnt_d   = CNT_W'(1);
        state_d = in_last ? PAD : RUN;
      end
      RUN: if (accept) begin
        cnt_d = cnt_q + 1'b1;
        if (in_last) state_d = (cnt_q >= LAST_CNT) ? IDLE : PAD;
      end
      PAD: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q >= LAST_CNT) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // One word per cycle while a vector is open: real element, bubble zero or pad zero
  always_comb begin
    in_ready = 1'b0;
    w_vld    = 1'b0;
    w_first  = 1'b0;
    w_last   = 1'b0;
    w_dat    = '0;
    case (state_q)
      IDLE: begin
        in_ready = has_credit;
        w_vld    = in_valid && has_credit;
        w_first  = w_vld;
        if (w_vld) w_dat = in_data;
      end
      RUN: begin
        in_ready = 1'b1;
        w_vld    = 1'b1;
        if (in_valid) w_dat = in_data;
        w_last   = in_valid && in_last && (cnt_q >= LAST_CNT);
      end
      PAD: begin
        w_vld  = 1'b1;
        w_last = cnt_q >= LAST_CNT;
      end
      default: ;
    endcase
    if (reset) in_ready = 1'b0;
  end

  always_comb begin
    acc_in_d   = s1_vld_q ? s1_dat_q : '0;
    stop_sr_d  = (stop_sr_q << 1) | STOP_OFFSET'(s2_last_q);
    inflight_d = inflight_q;
    if (idle_accept && !push)      inflight_d = inflight_q + 1'b1;
    else if (!idle_accept && push) inflight_d = inflight_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      inflight_q <= '0;
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_dat_q   <= '0;
      acc_in_q   <= '0;
      s2_last_q  <= 1'b0;
      stop_sr_q  <= '0;
      ov_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      s1_vld_q   <= w_vld;
      s1_first_q <= w_first;
      s1_last_q  <= w_last;
      s1_dat_q   <= w_dat;
      acc_in_q   <= acc_in_d;
      s2_last_q  <= s1_last_q;
      stop_sr_q  <= stop_sr_d;
      ov_q       <= core_ov;
    end
  end

  assign acc_start = s1_first_q;
  assign stop      = stop_sr_q[STOP_OFFSET-1];

  accumulator #(.ADD_LAT(STOP_OFFSET), .OUT_LAT(51)) u_core (
    .clk          (clk),
    .reset        (reset),
    .start        (acc_start),
    .stop         (stop),
    .acc_in       (acc_in_q),
    .output_valid (core_ov),
    .acc_out      (core_out)
  );

  accum_fifo #(.DEPTH(RES_DEPTH), .W($bits(complex_t)), .CW(CW)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (core_out),
    .pop      (out_valid && out_ready),
    .head_dat (head_raw),
    .count    (fifo_count)
  );

  assign head      = complex_t'(head_raw);
  assign out_valid = fifo_count != '0;
  assign out_data  = out_valid ? head : '0;
  assign busy      = (state_q != IDLE) || (inflight_q != '0) || (fifo_count != '0);
endmodule

// File: doc/accum_sequencer.md
# accum_sequencer

Sequences a ready/valid stream of complex products into the `accumulator` core, which it instantiates. It generates the core's `start`/`stop` pulses, enforces the core's 11-element minimum by zero padding, and fills input bubbles with zeros so the core sees a continuous stream. It buffers finished dot-product results in a credit-checked FIFO, so the unthrottled core output can never be lost. It sits between the complex multiplier array and the result writer in the conv layer AFU.

## Interface
- `RES_DEPTH`, default 8: result FIFO depth; also the maximum number of in-flight plus buffered results.
- `STOP_OFFSET`, default 11: cycles from presenting the last element on `acc_in` to the `stop` pulse. Equals the complexAdd latency.
- `CNT_W`, default 16: width of the element counter; maximum vector length is 2^CNT_W-1.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high; also drives the internal accumulator reset.
- `in_valid`  in  1  input element valid.
- `in_ready`  out  1  element accepted when `in_valid && in_ready`.
- `in_data`  in  complex_t  product element.
- `in_last`  in  1  marks the last element of a vector.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  result consumed when `out_valid && out_ready`.
- `out_data`  out  complex_t  dot-product result.
- `busy`  out  1  high while a vector is open, padding, or results are in flight or buffered.

## Operation
- States are IDLE, RUN and PAD.
- **Credits:** `credits = RES_DEPTH - (fifo_count + inflight)`, where `inflight` counts vectors whose start has been issued but whose result is not yet pushed.
- **IDLE**
  - `in_ready = (credits > 0)`.
  - On accepting an element: `inflight++` and `cnt = 1`.
  - If `in_last` is clear, go to RUN.
  - If `in_last` is set, go to PAD (a length-1 vector).
- **RUN**
  - `in_ready = 1`.
  - Each cycle pushes one word into the core pipeline: the accepted element, or (0,0) if no element was accepted.
  - Each accepted element increments `cnt`.
  - On the accepted `in_last`:
    - `cnt >= 11`: close the vector and go to IDLE.
    - Otherwise: go to PAD.
- **PAD**
  - `in_ready = 0`.
  - Pushes `11 - cnt` zeros, then closes the vector and goes to IDLE.
- **Vector boundaries**
  - The first element of the next vector may be accepted the cycle after the closing cycle, if a credit is free.
  - Vectors are therefore back-to-back, with stops at least 11 cycles apart.
- **Core pipeline** (two registered stages)
  - Stage 1 holds the word.
  - `acc_start` is asserted for one cycle, registered, in the cycle stage 1 holds the first word of a vector.
  - Stage 2 drives `acc_in`, so the first word reaches the core exactly one cycle after `start`.
  - Outside a vector, `acc_in = (0,0)`.
- **Stop:** a shift register of depth `STOP_OFFSET` delays the "last word presented" marker, and pulses `stop` `STOP_OFFSET` cycles after the last word (real or pad) appears on `acc_in`.
- **Result capture**
  - The core asserts `output_valid` one cycle before its output is valid.
  - The sequencer registers `output_valid` and, on the next cycle, pushes the core output into the FIFO and decrements `inflight`.
- **Arithmetic:** no widening or rounding. `out_data` is the core output bit-exact; component overflow wraps as in complexAdd.
- **FIFO**
  - First-word-fall-through, `RES_DEPTH` entries.
  - A push can never meet a full FIFO, by the credit rule. An assertion must fire if it does.
  - Simultaneous push and pop when full or empty is legal, and the count is unchanged.
  - When `inflight` is incremented and decremented in the same cycle, the value is unchanged.
- **Reset**
  - Reset mid-vector or with results in flight discards everything: FIFO, `inflight`, stop shift register, and core state.
  - No result from before reset ever appears on `out_data`.

## Timing
- **Reset values:** `in_ready=0` during reset and `1` the cycle after if `RES_DEPTH>0`; `out_valid=0`; `out_data=0`; `busy=0`; `acc_start=0`; `stop=0`; `acc_in=(0,0)`.
- **Latency** for a first element accepted at cycle t, length N >= 11, no bubbles:
  - `acc_start` at t+1.
  - First word on `acc_in` at t+2.
  - Last word at t+N+1.
  - `stop` at t+N+1+STOP_OFFSET.
  - Core `output_valid` 51 cycles later.
  - Push one cycle after that; `out_valid` the cycle after the push.
  - Total: `out_valid` at t+N+STOP_OFFSET+54.
- **Bubbles and padding:** each input bubble inside a vector, and each pad cycle, adds one cycle of latency.
- **Throughput:** one element per cycle sustained while credits remain; `in_ready` drops only in IDLE with zero credits, or in PAD.

## Test plan
- 16 elements of (1,0), no bubbles, `out_ready=1` -> one result (16,0) with `out_valid` at t+81. `acc_start` and `stop` each pulse exactly once.
- 3 elements (2,1),(2,1),(2,1) with `in_last` on the third -> `in_ready` low for 8 PAD cycles, 11 words presented, result (6,3).
- 12 elements of (1,-1) with `in_valid` deasserted for 5 cycles mid-vector -> result (12,-12), and latency is 5 cycles longer than without the gap.
- `out_ready=0`, 9 back-to-back 11-element vectors with values k=1..9 (each element (k,0)) -> 8 accepted, `in_ready` low on vector 9. Releasing `out_ready` yields (11,0)..(88,0) in order, then vector 9 is accepted and produces (99,0).
- Reset asserted 20 cycles after `stop` of an in-flight vector -> `out_valid` never rises for that vector. A following 11×(1,1) vector yields (11,11).
- Two back-to-back 11-element vectors of (1,0) and (0,1) -> `stop` pulses are 11 cycles apart, and the results are (11,0) then (0,11) with `out_valid` edges 11 cycles apart.
